// File: rtl/timer_sched_pkg.sv
// Shared timing helpers for the timer scheduler: clock-rate conversions,
// counter-width function and the channel state type.
package timer_sched_pkg;

  localparam int unsigned CLK_HZ = 32'd50_000_000;

  // Bits needed to hold a counter running 0..n-1 (never narrower than one bit).
  function automatic int unsigned cbit(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

  function automatic int unsigned c_ms(input int unsigned ms);
    return ms * (CLK_HZ / 32'd1000);
  endfunction

  function automatic int unsigned c_us(input int unsigned us);
    return us * (CLK_HZ / 32'd1_000_000);
  endfunction

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/timer_chan.sv
// One scheduler channel: counts shared base ticks down from a latched delay
// and emits a single-cycle fire pulse on expiry, optionally auto-reloading.
module timer_chan
  import timer_sched_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [DW-1:0] dly,
  output logic          busy,
  output logic          fire
);

  localparam logic [DW-1:0] ONE = DW'(1);

  chan_state_e   state_r, state_n;
  logic [DW-1:0] rem_r, rem_n;
  logic [DW-1:0] dly_r, dly_n;
  logic          mode_r, mode_n;
  logic          fire_r, fire_n;

  // A zero delay is treated as one tick so rem never has to go below 1.
  function automatic logic [DW-1:0] at_least_one(input logic [DW-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  // Next-state logic; stop beats start, start beats tick.
  always_comb begin
    state_n = state_r;
    rem_n   = rem_r;
    dly_n   = dly_r;
    mode_n  = mode_r;
    fire_n  = 1'b0;
    if (stop) begin
      state_n = CH_IDLE;
    end else if (start) begin
      dly_n   = dly;
      mode_n  = periodic;
      rem_n   = at_least_one(dly);
      state_n = CH_RUN;
    end else if (tick) begin
      case (state_r)
        CH_RUN: begin
          if (rem_r > ONE) begin
            rem_n = rem_r - ONE;
          end else begin
            fire_n = 1'b1;
            if (mode_r) begin
              rem_n = at_least_one(dly_r);
            end else begin
              state_n = CH_IDLE;
            end
          end
        end
        CH_IDLE: state_n = CH_IDLE;
        default: state_n = CH_IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CH_IDLE;
      rem_r   <= '0;
      dly_r   <= '0;
      mode_r  <= 1'b0;
      fire_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      rem_r   <= rem_n;
      dly_r   <= dly_n;
      mode_r  <= mode_n;
      fire_r  <= fire_n;
    end
  end

  assign busy = (state_r == CH_RUN);
  assign fire = fire_r;

endmodule

// File: rtl/timer_sched.sv
// Shared-timebase scheduler: one free-running prescaler produces a base tick
// every PRE clocks, consumed by NCH independent one-shot/periodic channels.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PRE = c_ms(1),
  parameter int DW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    periodic,
  input  logic [NCH*DW-1:0] dly,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    fire,
  output logic              tick
);

  localparam int PW = cbit(PRE);

  logic [PW-1:0] pcnt_r;
  logic          tick_r;

  // Prescaler; never restarted by channel activity, hence the start-to-fire jitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r <= '0;
      tick_r <= 1'b0;
    end else if (pcnt_r == PW'(PRE - 1)) begin
      pcnt_r <= '0;
      tick_r <= 1'b1;
    end else begin
      pcnt_r <= pcnt_r + PW'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    timer_chan #(.DW(DW)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick_r),
      .start    (start[i]),
      .stop     (stop[i]),
      .periodic (periodic[i]),
      .dly      (dly[i*DW +: DW]),
      .busy     (busy[i]),
      .fire     (fire[i])
    );
  end

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: directed scenarios then random traffic, each checked
// against an absolute-deadline model of the scheduler.
module tb_timer_sched;

  localparam int NCH = 4;
  localparam int PRE = 4;
  localparam int DW  = 16;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    start;
  logic [NCH-1:0]    stop;
  logic [NCH-1:0]    periodic;
  logic [NCH*DW-1:0] dly;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    fire;
  logic              tick;

  timer_sched #(.NCH(NCH), .PRE(PRE), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .dly      (dly),
    .busy     (busy),
    .fire     (fire),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: e = clock edges since reset release; each channel holds the
  // absolute edge number of its next expected fire.
  int             e;
  bit             act[NCH];
  bit             per[NCH];
  int             dd[NCH];
  int             nxt[NCH];
  logic [NCH-1:0] exp_fire;
  logic [NCH-1:0] exp_busy;
  logic           exp_tick;

  // Ticks become visible after edges PRE, 2*PRE, ... and are consumed one edge later.
  function automatic int first_fire(input int s, input int d);
    return ((s - 1) / PRE + 1) * PRE + 1 + (d - 1) * PRE;
  endfunction

  task automatic model_clear();
    e        = 0;
    exp_fire = '0;
    exp_busy = '0;
    exp_tick = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      act[c] = 1'b0;
      per[c] = 1'b0;
      dd[c]  = 1;
      nxt[c] = 0;
    end
  endtask

  task automatic model_edge();
    e        = e + 1;
    exp_tick = ((e % PRE) == 0);
    for (int c = 0; c < NCH; c++) begin
      exp_fire[c] = 1'b0;
      if (stop[c]) begin
        act[c] = 1'b0;
      end else if (start[c]) begin
        dd[c]  = (dly[c*DW +: DW] == 16'd0) ? 1 : int'(dly[c*DW +: DW]);
        per[c] = periodic[c];
        act[c] = 1'b1;
        nxt[c] = first_fire(e, dd[c]);
      end else if (act[c] && e == nxt[c]) begin
        exp_fire[c] = 1'b1;
        if (per[c]) nxt[c] = nxt[c] + dd[c] * PRE;
        else        act[c] = 1'b0;
      end
      exp_busy[c] = act[c];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_clear();
    #1;
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("fire", 32'(fire), 32'(exp_fire));
  endtask

  task automatic pulse(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    start = st;
    stop  = sp;
    step();
    start = '0;
    stop  = '0;
  endtask

  task automatic wait_fire(input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      step();
      if (fire[ch]) at = e;
    end
  endtask

  int s0, f1, f2, f3;

  initial begin
    rst_n    = 1'b0;
    start    = '0;
    stop     = '0;
    periodic = '0;
    dly      = '0;
    model_clear();
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;

    // Idle timebase: ticks at edges 4, 8, 12.
    repeat (12) step();

    // Ch0 one-shot dly=3 started on the edge that consumes a tick.
    dly[0*DW +: DW] = 16'd3;
    periodic        = 4'b0000;
    pulse(4'b0001, 4'b0000);
    s0 = e;
    wait_fire(0, 20, f1);
    chk("ch0_oneshot_latency", 32'(f1 - s0), 32'd12);
    repeat (12) step();

    // Ch1 periodic dly=2: three fires 8 clocks apart, then stop.
    dly[1*DW +: DW] = 16'd2;
    periodic        = 4'b0010;
    pulse(4'b0010, 4'b0000);
    wait_fire(1, 20, f1);
    wait_fire(1, 20, f2);
    chk("ch1_period_a", 32'(f2 - f1), 32'd8);
    wait_fire(1, 20, f3);
    chk("ch1_period_b", 32'(f3 - f2), 32'd8);
    pulse(4'b0000, 4'b0010);
    chk("ch1_stopped", 32'(busy[1]), 32'd0);
    repeat (12) step();

    // Ch2 dly=5 restarted mid-count with dly=1; ch3 dly=0 joins on the restart.
    periodic        = 4'b0000;
    dly[2*DW +: DW] = 16'd5;
    pulse(4'b0100, 4'b0000);
    repeat (6) step();
    dly[2*DW +: DW] = 16'd1;
    dly[3*DW +: DW] = 16'd0;
    pulse(4'b1100, 4'b0000);
    s0 = e;
    wait_fire(2, 12, f1);
    chk("ch2_restart_within_one_tick", 32'((f1 > s0) && (f1 - s0 <= PRE)), 32'd1);
    repeat (10) step();

    // Start and stop together: stop wins.
    dly[0*DW +: DW] = 16'd2;
    pulse(4'b0001, 4'b0001);
    chk("ch0_start_stop_idle", 32'(busy[0]), 32'd0);

    // Start on the edge that consumes a tick: tick ignored, full D*PRE wait.
    for (int k = 0; k < PRE && (e % PRE) != 0; k++) step();
    pulse(4'b0001, 4'b0000);
    s0 = e;
    wait_fire(0, 20, f1);
    chk("ch0_tick_not_consumed", 32'(f1 - s0), 32'd8);
    repeat (4) step();

    // All four channels dly=2 fire in the same clock.
    for (int c = 0; c < NCH; c++) dly[c*DW +: DW] = 16'd2;
    pulse(4'b1111, 4'b0000);
    wait_fire(0, 20, f1);
    chk("all_fire_together", 32'(fire), 32'hF);
    repeat (3) step();

    // Reset pulsed mid-count: everything clears, no pending fire survives.
    pulse(4'b1111, 4'b0000);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_fire", 32'(fire), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    model_clear();
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (16) step();

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < NCH; c++) begin
        dly[c*DW +: DW] = 16'($urandom_range(0, 3));
        periodic[c]     = ($urandom_range(0, 1) == 1);
        start[c]        = ($urandom_range(0, 15) == 0);
        stop[c]         = ($urandom_range(0, 31) == 0);
      end
      step();
    end
    start = '0;
    stop  = '0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
